// File: rtl/counter_pkg.sv
// Shared types, sizes and the count advance rule for the up/down LED counter.
package counter_pkg;

    typedef enum logic {
        PAUSE = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int COUNT_MAX = 5;
    localparam int COUNT_W   = 3;
    localparam int LED_W     = 6;

    // One step around the 0..COUNT_MAX ring in the requested direction.
    function automatic logic [COUNT_W-1:0] next_count(input logic [COUNT_W-1:0] cur,
                                                      input logic               up);
        logic [COUNT_W-1:0] nxt;
        if (up) begin
            nxt = (cur == COUNT_W'(COUNT_MAX)) ? '0 : cur + COUNT_W'(1);
        end else begin
            nxt = (cur == '0) ? COUNT_W'(COUNT_MAX) : cur - COUNT_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/counter_ctrl_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability down-counter and a
// one-cycle press pulse on each accepted rising level.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    localparam int             CW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(DB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          level_d;
    logic [CW-1:0] remain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            press   <= 1'b0;
            remain  <= RELOAD;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            press   <= level & ~level_d;
            // Any cycle agreeing with the accepted level restarts the stability window.
            if (sync2 == level) begin
                remain <= RELOAD;
            end else if (remain == '0) begin
                level  <= sync2;
                remain <= RELOAD;
            end else begin
                remain <= remain - CW'(1);
            end
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Run/pause/step controller for the 0..5 up/down LED counter: button
// conditioning, advance divider, run/pause FSM, count register and LED decode.
//
//   state | meaning
//   PAUSE | divider held at 0; step press advances once; run press -> RUN
//   RUN   | divider free-runs, terminal count advances; run press -> PAUSE
module counter_ctrl
    import counter_pkg::*;
#(
    parameter int TICK_DIV  = 100_000_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_run,
    input  logic               btn_dir,
    input  logic               btn_step,
    output logic [COUNT_W-1:0] q,
    output logic               up_down,
    output logic               running,
    output logic               tick,
    output logic [LED_W-1:0]   led
);

    localparam int               DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(TICK_DIV - 1);

    state_t             state;
    logic [DIV_W-1:0]   div;
    logic               press_run;
    logic               press_dir;
    logic               press_step;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_run),
        .press (press_run)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dir (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_dir),
        .press (press_dir)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk   (clk),
        .reset (reset),
        .btn   (btn_step),
        .press (press_step)
    );

    assign tick = (state == RUN) && (div == DIV_TC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= PAUSE;
            running <= 1'b0;
            div     <= '0;
            q       <= '0;
            up_down <= 1'b1;
        end else begin
            case (state)
                PAUSE: begin
                    div <= '0;
                    // A run press in the same cycle swallows any step press.
                    if (press_run) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (press_step) begin
                        q <= next_count(q, up_down);
                    end
                end
                RUN: begin
                    if (tick) begin
                        q <= next_count(q, up_down);
                    end
                    if (press_run) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                        div     <= '0;
                    end else begin
                        div <= (div == DIV_TC) ? '0 : div + DIV_W'(1);
                    end
                end
                default: begin
                    state   <= PAUSE;
                    running <= 1'b0;
                    div     <= '0;
                end
            endcase
            // Toggled after the advance above has already used the old direction.
            if (press_dir) begin
                up_down <= ~up_down;
            end
        end
    end

    assign led = LED_W'(1) << q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed-plus-random bench for counter_ctrl with a window-based button model
// and an arithmetic run/pause/count reference.
module tb_counter_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int DB_CYCLES = 3;
    localparam int B_RUN = 0, B_DIR = 1, B_STEP = 2;

    logic       clk;
    logic       reset;
    logic       btn_run, btn_dir, btn_step;
    logic [2:0] q;
    logic       up_down, running, tick;
    logic [5:0] led;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state.
    int        mq;
    bit        mdir, mrun;
    int        mage;
    bit [31:0] hist [3];
    bit        lvl  [3];
    bit [1:0]  pend [3];

    counter_ctrl #(.TICK_DIV(TICK_DIV), .DB_CYCLES(DB_CYCLES)) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_run  (btn_run),
        .btn_dir  (btn_dir),
        .btn_step (btn_step),
        .q        (q),
        .up_down  (up_down),
        .running  (running),
        .tick     (tick),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq = 0; mdir = 1'b1; mrun = 1'b0; mage = 0;
        for (int b = 0; b < 3; b++) begin
            hist[b] = '0; lvl[b] = 1'b0; pend[b] = '0;
        end
    endtask

    function automatic bit raw_btn(input int b);
        return (b == B_RUN) ? btn_run : (b == B_DIR) ? btn_dir : btn_step;
    endfunction

    function automatic bit exp_tick();
        return mrun && ((mage % TICK_DIV) == TICK_DIV - 1);
    endfunction

    task automatic model_edge();
        bit ev [3];
        bit adv, all_diff;
        if (reset) begin
            model_reset();
            return;
        end
        for (int b = 0; b < 3; b++) ev[b] = pend[b][1];
        adv = 1'b0;
        if (mrun) begin
            adv = exp_tick();
            if (ev[B_RUN]) mrun = 1'b0;
            else           mage++;
        end else if (ev[B_RUN]) begin
            mrun = 1'b1;
            mage = 0;
        end else if (ev[B_STEP]) begin
            adv = 1'b1;
        end
        if (adv) mq = mdir ? (mq + 1) % 6 : (mq + 5) % 6;
        if (ev[B_DIR]) mdir = !mdir;
        // Level flips when the last DB_CYCLES synchronized samples all disagree with it.
        for (int b = 0; b < 3; b++) begin
            hist[b] = {hist[b][30:0], raw_btn(b)};
            all_diff = 1'b1;
            for (int j = 2; j <= DB_CYCLES + 1; j++)
                if (hist[b][j] == lvl[b]) all_diff = 1'b0;
            if (all_diff) lvl[b] = !lvl[b];
            pend[b] = {pend[b][0], all_diff && lvl[b]};
        end
    endtask

    task automatic check_model();
        chk("q", q, mq);
        chk("up_down", up_down, mdir);
        chk("running", running, mrun);
        chk("tick", tick, exp_tick());
        chk("led", led, 1 << mq);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_btn(input int b, input logic v);
        if (b == B_RUN) btn_run = v;
        else if (b == B_DIR) btn_dir = v;
        else btn_step = v;
    endtask

    task automatic hold_btn(input int b, input int n);
        set_btn(b, 1'b1);
        repeat (n) cycle();
        set_btn(b, 1'b0);
    endtask

    // Called at +1 after an edge: asserts reset between edges and checks it takes effect at once.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        chk({tag, "_q"}, q, 0);
        chk({tag, "_up_down"}, up_down, 1);
        chk({tag, "_running"}, running, 0);
        chk({tag, "_tick"}, tick, 0);
        chk({tag, "_led"}, led, 6'b000001);
        model_reset();
        btn_run = 0; btn_dir = 0; btn_step = 0;
        idle(2);
        reset = 1'b0;
    endtask

    task automatic measure_step(input string tag, input logic [2:0] expq);
        logic [2:0] p;
        int n;
        p = q;
        btn_step = 1'b1;
        cycle();
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n++;
            if (q !== p) break;
        end
        btn_step = 1'b0;
        chk({tag, "_latency"}, n, 6);
        chk({tag, "_q"}, q, expq);
        idle(6);
    endtask

    task automatic measure_first_tick(input string tag, input logic [2:0] expq);
        logic [2:0] p;
        int n;
        for (int i = 0; i < 20 && running !== 1'b1; i++) cycle();
        chk({tag, "_running"}, running, 1);
        p = q;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n++;
            if (q !== p) break;
        end
        chk({tag, "_first_tick"}, n, TICK_DIV);
        chk({tag, "_q"}, q, expq);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_seq [7] = '{1, 2, 3, 4, 5, 0, 1};
        int seen [$];
        int when [$];
        int cyc;
        int hold_left [3];

        reset = 1'b1; btn_run = 0; btn_dir = 0; btn_step = 0;
        model_reset();
        idle(3);
        reset = 1'b0;
        idle(2);

        // Run and count up with wrap; tick spacing is exactly TICK_DIV.
        hold_btn(B_RUN, 5);
        cyc = 0;
        for (int i = 0; i < 80 && seen.size() < 7; i++) begin
            logic [2:0] p;
            p = q;
            cycle();
            cyc++;
            if (q !== p) begin
                seen.push_back(q);
                when.push_back(cyc);
            end
        end
        chk("wrap_count", seen.size(), 7);
        for (int i = 0; i < seen.size(); i++) chk("wrap_seq", seen[i], exp_seq[i]);
        for (int i = 1; i < when.size(); i++) chk("tick_period", when[i] - when[i-1], TICK_DIV);
        for (int i = 0; i < 40 && mq != 3; i++) cycle();
        chk("run_q3", q, 3);

        // Reset mid-run, then no ticks without a new run press.
        async_reset("rst_run");
        idle(12);

        // Paused down-count with wrap, latency from raw edge.
        hold_btn(B_DIR, 4);
        idle(6);
        chk("dir_down", up_down, 0);
        measure_step("step1", 3'd5);
        measure_step("step2", 3'd4);

        // Bounce rejection.
        hold_btn(B_STEP, 2);
        idle(8);
        chk("short_pulse_q", q, 4);
        hold_btn(B_STEP, 10);
        idle(6);
        chk("long_hold_q", q, 3);
        for (int i = 0; i < 4; i++) begin
            hold_btn(B_STEP, $urandom_range(1, 2));
            idle($urandom_range(1, 2));
        end
        hold_btn(B_STEP, 6);
        for (int i = 0; i < 6; i++) begin
            idle($urandom_range(1, 2));
            hold_btn(B_STEP, $urandom_range(1, 2));
        end
        idle(8);
        chk("bounce_q", q, 2);

        // Direction back to up, then run+step together in PAUSE.
        hold_btn(B_DIR, 4);
        idle(6);
        chk("dir_up", up_down, 1);
        btn_run = 1'b1; btn_step = 1'b1;
        idle(5);
        btn_run = 1'b0; btn_step = 1'b0;
        measure_first_tick("run_step", 3'd3);

        // Dir press coincident with the tick taking q from 2 to 3.
        for (int i = 0; i < 60 && !(mq == 1 && (mage % TICK_DIV) == 0); i++) cycle();
        chk("align_q1", q, 1);
        cycle();
        hold_btn(B_DIR, 4);
        idle(3);
        chk("coinc_q", q, 3);
        chk("coinc_dir", up_down, 0);
        idle(4);
        chk("after_coinc_q", q, 2);

        // Pause landing while the divider is at 2.
        for (int i = 0; i < 10 && (mage % TICK_DIV) != 0; i++) cycle();
        hold_btn(B_RUN, 4);
        idle(3);
        chk("pause_running", running, 0);
        chk("pause_q", q, 1);
        idle(10);
        chk("frozen_q", q, 1);
        hold_btn(B_STEP, 4);
        idle(6);
        chk("pause_step_q", q, 0);
        hold_btn(B_RUN, 4);
        measure_first_tick("resume", 3'd5);

        // A partially debounced press must not survive reset.
        btn_run = 1'b1;
        idle(3);
        async_reset("rst_deb");
        idle(12);
        chk("rst_deb_running", running, 0);

        // Random button activity against the reference.
        for (int b = 0; b < 3; b++) hold_left[b] = 0;
        for (int i = 0; i < 500; i++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold_left[b] == 0) begin
                    set_btn(b, 1'($urandom_range(0, 1)));
                    hold_left[b] = $urandom_range(1, 8);
                end
                hold_left[b]--;
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
